// File: rtl/proc_pkg.sv
// Shared definitions for the program fetch sequencer: lifecycle states and
// the table of resident program entry addresses.
package proc_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int NUM_ENTRIES  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LAUNCH,
    RUN,
    HALTED
  } seq_state_t;

  localparam logic [PC_W_DEFAULT-1:0] ENTRY [NUM_ENTRIES] = '{
    PC_W_DEFAULT'(0),
    PC_W_DEFAULT'(256),
    PC_W_DEFAULT'(512)
  };

  // Program index successor, wrapping back to 0 after the last resident program.
  function automatic logic [1:0] nextProg(input logic [1:0] cur, input int numProgs);
    return (int'(cur) >= numProgs - 1) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         Enable,
  output logic [W-1:0] Count
);

  logic [W-1:0] countReg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      countReg <= '0;
    end else if (Clear) begin
      countReg <= '0;
    end else if (Enable && (countReg != {W{1'b1}})) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign Count = countReg;

endmodule

// File: rtl/prog_sequencer.sv
// Fetch controller: waits for a full Start pulse, loads the PC with the current
// program's entry address, advances it until a decoded halt, then reports Done.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int NUM_PROGS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcTarget,
  output logic             PcAdvance,
  output logic             Running,
  output logic             Done,
  output logic [1:0]       ProgNum,
  output logic [CNT_W-1:0] CycleCount
);

  seq_state_t stateReg;
  seq_state_t stateNext;
  logic [1:0] progNumReg;
  logic [PC_W-1:0] entryAddr;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // The next program is selected when leaving HALTED, so ProgNum keeps naming
  // the last program for as long as Done is shown.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      progNumReg <= 2'd0;
    end else if ((stateReg == HALTED) && Start) begin
      progNumReg <= nextProg(progNumReg, NUM_PROGS);
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (Start)  stateNext = ARMED;
      ARMED:   if (!Start) stateNext = LAUNCH;
      LAUNCH:  stateNext = RUN;
      RUN:     if (Halt)   stateNext = HALTED;
      HALTED:  if (Start)  stateNext = ARMED;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    entryAddr = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (progNumReg == 2'(i)) entryAddr = PC_W'(ENTRY[i]);
    end
  end

  always_comb begin
    PcLoad    = 1'b0;
    PcTarget  = '0;
    PcAdvance = 1'b0;
    Running   = 1'b0;
    Done      = 1'b0;
    case (stateReg)
      LAUNCH: begin
        PcLoad   = 1'b1;
        PcTarget = entryAddr;
      end
      RUN: begin
        Running   = 1'b1;
        PcAdvance = !Stall && !Halt;
      end
      HALTED:  Done = 1'b1;
      default: ;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) cycleCounter (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (stateReg == LAUNCH),
    .Enable (stateReg == RUN),
    .Count  (CycleCount)
  );

  assign ProgNum = progNumReg;

endmodule
